caixa_dagua_sim: RTL and testbench

Closed-loop plant model of the irrigation water tank. It consumes the actuator commands the irrigation controller drives: Ve (inlet valve), Bs (sprinkler pump) and Vs (drip valve). From them it integrates a tank level and produces the H/M/L level-sensor signals that the controller reads. It replaces the physical float switches on the FPGA demo board and in system benches, and can inject sensor faults so the controller's ERRO/alarm path can be exercised.

---
 rtl/rega_pkg.sv | 52 +++++
 rtl/divisor_passo.sv | 35 +++
 rtl/caixa_dagua_sim.sv | 146 ++++++++++++++
 tb/tb_caixa_dagua_sim.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// Shared encodings for the tank plant model: zones,
// fault codes and H/M/L sensor patterns.
package rega_pkg;

  localparam logic [1:0] Z_CRIT = 2'd0;
  localparam logic [1:0] Z_LOW  = 2'd1;
  localparam logic [1:0] Z_MED  = 2'd2;
  localparam logic [1:0] Z_HIGH = 2'd3;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_H1   = 2'b01;
  localparam logic [1:0] F_M0   = 2'b10;
  localparam logic [1:0] F_L0   = 2'b11;

  // Bit order is {H, M, L}
  localparam logic [2:0] S_CRIT = 3'b000;
  localparam logic [2:0] S_LOW  = 3'b001;
  localparam logic [2:0] S_MED  = 3'b011;
  localparam logic [2:0] S_HIGH = 3'b111;

  function automatic logic [2:0] zone_map(
    input logic [1:0] z
  );
    logic [2:0] s;
    s = S_CRIT;
    unique case (z)
      Z_CRIT: s = S_CRIT;
      Z_LOW:  s = S_LOW;
      Z_MED:  s = S_MED;
      Z_HIGH: s = S_HIGH;
      default: s = S_CRIT;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] fault_apply(
    input logic [2:0] s,
    input logic [1:0] f
  );
    logic [2:0] r;
    r = s;
    unique case (f)
      F_NONE: r = s;
      F_H1:   r = s | 3'b100;
      F_M0:   r = s & 3'b101;
      F_L0:   r = s & 3'b110;
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/divisor_passo.sv
// Free-running step prescaler: one-cycle passo every DIV
// cycles; pausa freezes the count.
module divisor_passo #(
  parameter int DIV = 50_000_000
) (
  input  logic clock,
  input  logic Rst,
  input  logic pausa,
  output logic passo
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign passo = (cnt_q == LAST) && !pausa;

  always_comb begin
    cnt_d = cnt_q;
    if (!pausa) begin
      cnt_d = passo ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/caixa_dagua_sim.sv
// Water tank plant: integrates level from Ve/Bs/Vs and
// drives H/M/L float sensors with hysteresis and faults.
module caixa_dagua_sim
  import rega_pkg::*;
#(
  parameter int DIV        = 50_000_000,
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int INIT_LEVEL = 100,
  parameter int L_TH       = 20,
  parameter int M_TH       = 100,
  parameter int H_TH       = 180,
  parameter int HYST       = 4,
  parameter int FILL_RATE  = 4,
  parameter int BS_RATE    = 3,
  parameter int VS_RATE    = 1
) (
  input  logic               clock,
  input  logic               Rst,
  input  logic               Ve,
  input  logic               Bs,
  input  logic               Vs,
  input  logic               pausa,
  input  logic [1:0]         fault_sel,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic [LEVEL_W-1:0] Nivel,
  output logic               Transbordo,
  output logic [7:0]         overflow_cnt
);

  localparam int SW = LEVEL_W + 2;

  localparam logic signed [SW-1:0] ZERO_S = '0;
  localparam logic signed [SW-1:0] MAX_S  = SW'(MAX_LEVEL);
  localparam logic signed [SW-1:0] FR_S   = SW'(FILL_RATE);
  localparam logic signed [SW-1:0] BR_S   = SW'(BS_RATE);
  localparam logic signed [SW-1:0] VR_S   = SW'(VS_RATE);

  localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] INIT_L = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] LT_R   = LEVEL_W'(L_TH);
  localparam logic [LEVEL_W-1:0] MT_R   = LEVEL_W'(M_TH);
  localparam logic [LEVEL_W-1:0] HT_R   = LEVEL_W'(H_TH);
  localparam logic [LEVEL_W-1:0] LT_F   = LEVEL_W'(L_TH - HYST);
  localparam logic [LEVEL_W-1:0] MT_F   = LEVEL_W'(M_TH - HYST);
  localparam logic [LEVEL_W-1:0] HT_F   = LEVEL_W'(H_TH - HYST);

  localparam logic [1:0] Z_INIT =
    (INIT_LEVEL >= H_TH) ? Z_HIGH :
    (INIT_LEVEL >= M_TH) ? Z_MED  :
    (INIT_LEVEL >= L_TH) ? Z_LOW  : Z_CRIT;

  logic passo;

  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [1:0]         zone_q, zone_d;
  logic [2:0]         sens_q, sens_d;
  logic               tr_q, tr_d;
  logic [7:0]         ocnt_q, ocnt_d;

  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] sum;
  logic                 hi_on, me_on, lo_on;

  divisor_passo #(
    .DIV(DIV)
  ) u_div (
    .clock(clock),
    .Rst  (Rst),
    .pausa(pausa),
    .passo(passo)
  );

  always_comb begin
    delta = ZERO_S;
    if (Ve) delta = delta + FR_S;
    if (Bs) delta = delta - BR_S;
    if (Vs) delta = delta - VR_S;
    sum = $signed({2'b00, lvl_q}) + delta;
  end

  always_comb begin
    lvl_d  = lvl_q;
    tr_d   = 1'b0;
    ocnt_d = ocnt_q;
    if (passo) begin
      if (sum < ZERO_S) begin
        lvl_d = '0;
      end else if (sum > MAX_S) begin
        lvl_d = MAX_L;
      end else begin
        lvl_d = sum[LEVEL_W-1:0];
      end
      // Only spilling over a full tank counts; dry clamp is silent
      if (lvl_q == MAX_L && delta > ZERO_S) begin
        tr_d = 1'b1;
        if (ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    hi_on = (lvl_q >= HT_R) ||
            (zone_q == Z_HIGH && lvl_q >= HT_F);
    me_on = (lvl_q >= MT_R) ||
            (zone_q >= Z_MED && lvl_q >= MT_F);
    lo_on = (lvl_q >= LT_R) ||
            (zone_q >= Z_LOW && lvl_q >= LT_F);
    if (hi_on) begin
      zone_d = Z_HIGH;
    end else if (me_on) begin
      zone_d = Z_MED;
    end else if (lo_on) begin
      zone_d = Z_LOW;
    end else begin
      zone_d = Z_CRIT;
    end
    sens_d = fault_apply(zone_map(zone_d), fault_sel);
  end

  always_ff @(posedge clock) begin
    if (Rst) begin
      lvl_q  <= INIT_L;
      zone_q <= Z_INIT;
      sens_q <= zone_map(Z_INIT);
      tr_q   <= 1'b0;
      ocnt_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      zone_q <= zone_d;
      sens_q <= sens_d;
      tr_q   <= tr_d;
      ocnt_q <= ocnt_d;
    end
  end

  assign H            = sens_q[2];
  assign M            = sens_q[1];
  assign L            = sens_q[0];
  assign Nivel        = lvl_q;
  assign Transbordo   = tr_q;
  assign overflow_cnt = ocnt_q;

endmodule

// File: tb/tb_caixa_dagua_sim.sv
// Scoreboard bench for caixa_dagua_sim with DIV=4:
// stimulus queues timed expectations, monitor checks them.
module tb_caixa_dagua_sim;

  logic       clock = 1'b0;
  logic       Rst;
  logic       Ve, Bs, Vs, pausa;
  logic [1:0] fault_sel;
  logic       H, M, L;
  logic [7:0] Nivel;
  logic       Transbordo;
  logic [7:0] overflow_cnt;

  caixa_dagua_sim #(
    .DIV(4)
  ) dut (
    .clock       (clock),
    .Rst         (Rst),
    .Ve          (Ve),
    .Bs          (Bs),
    .Vs          (Vs),
    .pausa       (pausa),
    .fault_sel   (fault_sel),
    .H           (H),
    .M           (M),
    .L           (L),
    .Nivel       (Nivel),
    .Transbordo  (Transbordo),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         at;
    string      nm;
    logic [3:0] m;
    logic [7:0] niv;
    logic [2:0] hml;
    logic       tr;
    logic [7:0] oc;
  } exp_t;

  localparam logic [3:0] NV = 4'b0001;
  localparam logic [3:0] HM = 4'b0010;
  localparam logic [3:0] TR = 4'b0100;
  localparam logic [3:0] OC = 4'b1000;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   rel;
  int   sr;
  int   t0;
  int   x;

  task automatic chk(input int at, input string nm,
                     input logic [3:0] m,
                     input logic [7:0] niv,
                     input logic [2:0] hml,
                     input logic tr,
                     input logic [7:0] oc);
    exp_t e;
    int   i;
    e.at = at; e.nm = nm; e.m = m;
    e.niv = niv; e.hml = hml; e.tr = tr; e.oc = oc;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  function automatic int S(input int k);
    return rel + 3 + 4 * (k - 1);
  endfunction

  function automatic int D(input int j);
    return S(28 + j);
  endfunction

  task automatic wait_until(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != c) begin
      bad++;
      total++;
      $display("FAIL sched: cycle %0d want %0d", cyc, c);
    end
  endtask

  // Monitor: compares queued expectations 1 time unit after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        if (e.at < cyc) begin
          total++; bad++;
          $display("FAIL %s: missed at %0d", e.nm, e.at);
        end else begin
          if (e.m[0]) begin
            total++;
            if (Nivel !== e.niv) begin
              bad++;
              $display("FAIL %s Nivel: got %0d want %0d",
                       e.nm, Nivel, e.niv);
            end
          end
          if (e.m[1]) begin
            total++;
            if ({H, M, L} !== e.hml) begin
              bad++;
              $display("FAIL %s HML: got %b want %b",
                       e.nm, {H, M, L}, e.hml);
            end
          end
          if (e.m[2]) begin
            total++;
            if (Transbordo !== e.tr) begin
              bad++;
              $display("FAIL %s Transbordo: got %b want %b",
                       e.nm, Transbordo, e.tr);
            end
          end
          if (e.m[3]) begin
            total++;
            if (overflow_cnt !== e.oc) begin
              bad++;
              $display("FAIL %s ovf_cnt: got %0d want %0d",
                       e.nm, overflow_cnt, e.oc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int guard;
    Rst = 1'b1; Ve = 1'b0; Bs = 1'b0; Vs = 1'b0;
    pausa = 1'b0; fault_sel = 2'b00;
    repeat (3) @(negedge clock);
    rel = cyc + 1;

    chk(rel, "reset", NV | HM | TR | OC, 100, 3'b011, 0, 0);
    chk(rel + 2, "pre_step", NV, 100, 0, 0, 0);
    chk(S(1), "step1", NV, 104, 0, 0, 0);
    chk(S(20), "lvl180", NV | HM, 180, 3'b011, 0, 0);
    chk(S(20) + 1, "h_on", HM, 0, 3'b111, 0, 0);
    chk(S(25), "full", NV | TR | OC, 200, 0, 0, 0);
    chk(S(26), "ovf1", NV | TR | OC, 200, 0, 1, 1);
    chk(S(26) + 1, "ovf1_end", TR | OC, 0, 0, 0, 1);
    chk(S(27), "ovf2", TR | OC, 0, 0, 1, 2);
    chk(S(28), "ovf3", NV | TR | OC, 200, 0, 1, 3);
    chk(S(28) + 1, "ovf3_end", TR | OC, 0, 0, 0, 3);
    Rst = 1'b0;
    Ve  = 1'b1;

    chk(D(1), "drain1", NV | HM, 196, 3'b111, 0, 0);
    chk(D(6) + 1, "h_hold176", NV | HM, 176, 3'b111, 0, 0);
    chk(D(7) + 1, "h_off172", NV | HM, 172, 3'b011, 0, 0);
    chk(D(26) + 1, "m_hold96", NV | HM, 96, 3'b011, 0, 0);
    chk(D(27) + 1, "m_off92", NV | HM, 92, 3'b001, 0, 0);
    chk(D(46) + 1, "l_hold16", NV | HM, 16, 3'b001, 0, 0);
    chk(D(47) + 1, "l_off12", NV | HM, 12, 3'b000, 0, 0);
    chk(D(50), "empty", NV | TR, 0, 0, 0, 0);
    chk(D(51), "dry_clamp", NV | TR | OC, 0, 0, 0, 3);
    chk(D(51) + 1, "dry_nopulse", TR, 0, 0, 0, 0);
    wait_until(S(28));
    Ve = 1'b0; Bs = 1'b1; Vs = 1'b1;

    wait_until(D(51));
    Bs = 1'b0; Vs = 1'b0; Ve = 1'b1;
    sr = D(52);
    chk(sr, "rst_step", NV | HM | TR | OC, 100, 3'b011, 0, 0);
    chk(sr + 3, "rst_prestep", NV, 100, 0, 0, 0);
    chk(sr + 4, "rst_step1", NV, 104, 0, 0, 0);
    chk(sr + 8, "paused", NV, 104, 0, 0, 0);
    chk(sr + 17, "pause_pre", NV, 104, 0, 0, 0);
    chk(sr + 18, "pause_step", NV, 108, 0, 0, 0);
    wait_until(sr - 1);
    Rst = 1'b1;
    wait_until(sr);
    Rst = 1'b0;
    wait_until(sr + 4);
    pausa = 1'b1;
    wait_until(sr + 14);
    pausa = 1'b0;

    t0 = sr + 18;
    x  = t0 + 66;
    chk(t0 + 56, "lvl52", NV, 52, 0, 0, 0);
    chk(t0 + 57, "low52", HM, 0, 3'b001, 0, 0);
    chk(t0 + 64, "lvl50", NV | HM, 50, 3'b001, 0, 0);
    chk(x, "pre_fault", HM, 0, 3'b001, 0, 0);
    chk(x + 1, "fault_h", HM, 0, 3'b101, 0, 0);
    chk(x + 3, "fault_hold", HM, 0, 3'b101, 0, 0);
    chk(x + 4, "fault_clr", HM, 0, 3'b001, 0, 0);
    chk(x + 7, "fault_l", NV | HM, 50, 3'b000, 0, 0);
    wait_until(t0);
    Ve = 1'b0; Bs = 1'b1; Vs = 1'b1;
    wait_until(t0 + 56);
    Bs = 1'b0;
    wait_until(t0 + 64);
    Vs = 1'b0;
    wait_until(x);
    fault_sel = 2'b01;
    wait_until(x + 3);
    fault_sel = 2'b00;
    wait_until(x + 6);
    fault_sel = 2'b11;

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d checks left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
